// File: rtl/dispense_sequencer_if.sv
// Pi-side control/status bundle for the dispense sequencer.
// The Pi (master) drives requests and settings; the sequencer (slave) drives motors and status.
interface dispense_sequencer_if #(
   parameter int DUTY_W = 7,
   parameter int CNT_W  = 16
);
   logic              req;
   logic [1:0]        amount;
   logic              abort;
   logic              dir;
   logic [DUTY_W-1:0] duty;
   logic              step_o;
   logic              dir_o;
   logic              dc_in1;
   logic              dc_in2;
   logic              dc_pwm;
   logic              busy;
   logic              done;
   logic              err;
   logic [CNT_W-1:0]  steps_left;

   modport master (
      output req, amount, abort, dir, duty,
      input  step_o, dir_o, dc_in1, dc_in2, dc_pwm, busy, done, err, steps_left
   );

   modport slave (
      input  req, amount, abort, dir, duty,
      output step_o, dir_o, dc_in1, dc_in2, dc_pwm, busy, done, err, steps_left
   );
endinterface

// File: rtl/dispense_sequencer.sv
// Dispense sequencer: steps a stepper a table-selected number of steps while running a
// PWM-driven DC motor, keeps the DC motor running for a settle time, then handshakes done to the Pi.
module dispense_sequencer #(
   parameter int STEP_DIV    = 4000,
   parameter int PWM_PERIOD  = 100,
   parameter int DUTY_W      = 7,
   parameter int CNT_W       = 16,
   parameter int STEPS_SMALL = 200,
   parameter int STEPS_MED   = 400,
   parameter int STEPS_LARGE = 600,
   parameter int SETTLE_CYC  = 1000
) (
   input  logic           clk,
   input  logic           rstn,
   dispense_sequencer_if.slave bus
);
   localparam int DIV_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
   localparam int PWM_W = $clog2(PWM_PERIOD);
   localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

   typedef enum logic [2:0] {IDLE, RUN, SETTLE, DONE, ERROR} state_t;

   state_t state, state_nxt;

   logic              req_p0, req_p1, req_p2, abort_p0, abort_p1, vld_p0, vld_p1, armed;
   logic [1:0]        amount_p0, amount_p1;
   logic              req_rise, div_wrap, drive;
   logic [DIV_W-1:0]  div_cnt, div_d;
   logic [PWM_W-1:0]  pwm_cnt, pwm_d;
   logic [SET_W-1:0]  settle_cnt, settle_d;
   logic [CNT_W-1:0]  steps_left, steps_d;
   logic [DUTY_W-1:0] duty_l, duty_d;
   logic              step_r, step_d, dir_r, dir_d;
   logic              dc_in1_r, dc_in1_d, dc_in2_r, dc_in2_d, dc_pwm_r, dc_pwm_d;
   logic              busy_r, busy_d, done_r, done_d, err_r, err_d;

   function automatic logic [CNT_W-1:0] steps_for(input logic [1:0] code);
      case (code)
         2'b00:   return CNT_W'(STEPS_SMALL);
         2'b01:   return CNT_W'(STEPS_MED);
         default: return CNT_W'(STEPS_LARGE);
      endcase
   endfunction

   function automatic logic [PWM_W-1:0] pwm_step(input logic [PWM_W-1:0] c);
      return (c == PWM_W'(PWM_PERIOD - 1)) ? '0 : c + 1'b1;
   endfunction

   // Stage p0/p1: two-flop synchronisers; p2 is the previous req for edge detection.
   // armed only after the chain has refilled and req was seen low, so a req held
   // high across reset release never counts as a rising edge.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         req_p0    <= 1'b0;
         req_p1    <= 1'b0;
         req_p2    <= 1'b0;
         abort_p0  <= 1'b0;
         abort_p1  <= 1'b0;
         amount_p0 <= 2'b00;
         amount_p1 <= 2'b00;
         vld_p0    <= 1'b0;
         vld_p1    <= 1'b0;
         armed     <= 1'b0;
      end else begin
         req_p0    <= bus.req;
         req_p1    <= req_p0;
         req_p2    <= req_p1;
         abort_p0  <= bus.abort;
         abort_p1  <= abort_p0;
         amount_p0 <= bus.amount;
         amount_p1 <= amount_p0;
         vld_p0    <= 1'b1;
         vld_p1    <= vld_p0;
         if (vld_p1 && !req_p1) armed <= 1'b1;
      end
   end

   assign req_rise = armed && req_p1 && !req_p2;
   assign div_wrap = (div_cnt == DIV_W'(STEP_DIV - 1));

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (req_rise) state_nxt = (amount_p1 == 2'b11) ? ERROR : RUN;
         RUN:     if (abort_p1 || (div_wrap && step_r && steps_left == CNT_W'(1)))
                     state_nxt = SETTLE;
         SETTLE:  if (settle_cnt == SET_W'(SETTLE_CYC - 1)) state_nxt = DONE;
         DONE,
         ERROR:   if (!req_p1) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs are computed from the next state so that the registered copies line up with it.
   always_comb begin
      step_d   = 1'b0;
      div_d    = '0;
      pwm_d    = '0;
      settle_d = '0;
      steps_d  = steps_left;
      dir_d    = dir_r;
      duty_d   = duty_l;
      case (state)
         IDLE: begin
            if (req_rise && amount_p1 != 2'b11) begin
               steps_d = steps_for(amount_p1);
               dir_d   = bus.dir;
               duty_d  = bus.duty;
            end
         end
         RUN: begin
            pwm_d = pwm_step(pwm_cnt);
            if (!abort_p1) begin
               if (div_wrap) begin
                  step_d = !step_r;
                  if (step_r) steps_d = steps_left - 1'b1;
               end else begin
                  step_d = step_r;
                  div_d  = div_cnt + 1'b1;
               end
            end
         end
         SETTLE: begin
            pwm_d    = pwm_step(pwm_cnt);
            settle_d = settle_cnt + 1'b1;
         end
         default: ;
      endcase
      drive    = (state_nxt == RUN) || (state_nxt == SETTLE);
      dc_in1_d = drive;
      dc_in2_d = 1'b0;
      dc_pwm_d = drive && (32'(pwm_d) < 32'(duty_d));
      busy_d   = drive;
      done_d   = (state_nxt == DONE) || (state_nxt == ERROR);
      err_d    = (state_nxt == ERROR);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         div_cnt    <= '0;
         pwm_cnt    <= '0;
         settle_cnt <= '0;
         steps_left <= '0;
         duty_l     <= '0;
         dir_r      <= 1'b0;
         step_r     <= 1'b0;
         dc_in1_r   <= 1'b0;
         dc_in2_r   <= 1'b0;
         dc_pwm_r   <= 1'b0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         err_r      <= 1'b0;
      end else begin
         div_cnt    <= div_d;
         pwm_cnt    <= pwm_d;
         settle_cnt <= settle_d;
         steps_left <= steps_d;
         duty_l     <= duty_d;
         dir_r      <= dir_d;
         step_r     <= step_d;
         dc_in1_r   <= dc_in1_d;
         dc_in2_r   <= dc_in2_d;
         dc_pwm_r   <= dc_pwm_d;
         busy_r     <= busy_d;
         done_r     <= done_d;
         err_r      <= err_d;
      end
   end

   assign bus.step_o     = step_r;
   assign bus.dir_o      = dir_r;
   assign bus.dc_in1     = dc_in1_r;
   assign bus.dc_in2     = dc_in2_r;
   assign bus.dc_pwm     = dc_pwm_r;
   assign bus.busy       = busy_r;
   assign bus.done       = done_r;
   assign bus.err        = err_r;
   assign bus.steps_left = steps_left;
endmodule
